// File: rtl/rr_arbiter_8_enc.sv
// Round-robin arbiter for 8 requesters with registered grant index/enable for a 3-to-8 decoder.
// Optional grant statistics counter enabled by defining ARB_STATS_EN.
module rr_arbiter_8_enc #(
    parameter int HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  req,
    input  logic        done,
    output logic [2:0]  idx,
    output logic        enab,
    output logic        busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt
`endif
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

    state_t      state_reg, state_next;
    logic [2:0]  idx_reg, idx_next;
    logic [2:0]  ptr_reg, ptr_next;
    logic [15:0] hold_reg, hold_next;
    logic        grant_evt;

    logic [7:0]  rot_req;
    logic [2:0]  offset;
    logic [2:0]  winner;
    logic        release_cond;

    // rot_req[k] is the request that sits k places after the search pointer
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            localparam logic [2:0] OFF = 3'(gi);
            assign rot_req[gi] = req[ptr_reg + OFF];
        end
    endgenerate

    always_comb begin
        offset = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rot_req[k]) offset = 3'(k);
        end
    end

    assign winner = ptr_reg + offset;

    // ptr already points past the owner, so a plain search leaves it last in line
    assign release_cond = done || !req[idx_reg] ||
                          ((HOLD_MAX != 0) && (hold_reg == HOLD_LAST));

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        hold_next  = hold_reg;
        grant_evt  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = GRANT;
                    idx_next   = winner;
                    ptr_next   = winner + 3'd1;
                    hold_next  = 16'd0;
                    grant_evt  = 1'b1;
                end
            end
            GRANT: begin
                if (!release_cond) begin
                    hold_next = hold_reg + 16'd1;
                end else if (|req) begin
                    idx_next  = winner;
                    ptr_next  = winner + 3'd1;
                    hold_next = 16'd0;
                    grant_evt = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            ptr_reg   <= 3'd0;
            hold_reg  <= 16'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
            hold_reg  <= hold_next;
        end
    end

    assign idx  = idx_reg;
    assign enab = (state_reg == GRANT);
    assign busy = (state_reg == GRANT);

`ifdef ARB_STATS_EN
    logic [15:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= 16'd0;
        end else if (grant_evt && (cnt_reg != 16'hFFFF)) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign grant_cnt = cnt_reg;
`else
    logic unused_grant_evt;
    assign unused_grant_evt = grant_evt;
`endif

endmodule

// File: tb/tb_rr_arbiter_8_enc.sv
// Self-checking bench for rr_arbiter_8_enc: behavioural model feeds a scoreboard queue,
// plus directed checks of the key scenarios. Build with or without ARB_STATS_EN.
module tb_rr_arbiter_8_enc;

    localparam int HM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic        done;
    logic [2:0]  idx;
    logic        enab;
    logic        busy;
    logic [15:0] grant_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_8_enc #(.HOLD_MAX(HM)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .done (done),
        .idx  (idx),
        .enab (enab),
        .busy (busy)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

`ifndef ARB_STATS_EN
    assign grant_cnt = 16'd0;
`endif

    typedef struct packed {
        logic [2:0]  idx;
        logic        enab;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    logic [2:0]  m_idx  = 3'd0;
    logic [2:0]  m_ptr  = 3'd0;
    logic        m_enab = 1'b0;
    logic [15:0] m_hold = 16'd0;
    logic [15:0] m_cnt  = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] find_win(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] j;
        for (int k = 7; k >= 0; k--) begin
            j = p + 3'(k);
            if (r[j]) find_win = j;
        end
        if (r == 8'd0) find_win = p;
    endfunction

    task automatic model_grant(input logic [7:0] r);
        logic [2:0] w;
        w      = find_win(r, m_ptr);
        m_idx  = w;
        m_ptr  = w + 3'd1;
        m_enab = 1'b1;
        m_hold = 16'd0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic model_step(input logic r, input logic [7:0] rq, input logic d);
        logic rel;
        if (r) begin
            m_idx = 3'd0; m_ptr = 3'd0; m_enab = 1'b0; m_hold = 16'd0; m_cnt = 16'd0;
        end else if (!m_enab) begin
            if (rq != 8'd0) model_grant(rq);
        end else begin
            rel = d || !rq[m_idx] || (m_hold == 16'(HM - 1));
            if (!rel)              m_hold = m_hold + 16'd1;
            else if (rq != 8'd0)   model_grant(rq);
            else                   m_enab = 1'b0;
        end
    endtask

    // Drive one cycle, queue the model's expectation, compare after the edge
    task automatic cycle(input logic r, input logic [7:0] rq, input logic d);
        exp_t e;
        rst = r; req = rq; done = d;
        model_step(r, rq, d);
        e.idx = m_idx; e.enab = m_enab; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_idx", 32'(idx), 32'(e.idx));
        check("sb_enab", 32'(enab), 32'(e.enab));
        check("sb_busy", 32'(busy), 32'(e.enab));
`ifdef ARB_STATS_EN
        check("sb_cnt", 32'(grant_cnt), 32'(e.cnt));
`endif
        $display("t=%0t rst=%0b req=%02h done=%0b -> idx=%0d enab=%0b busy=%0b cnt=%0d",
                 $time, r, rq, d, idx, enab, busy, grant_cnt);
    endtask

    initial begin
        rst = 1'b1; req = 8'hFF; done = 1'b0;

        // reset held with all requests asserted
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 8'hFF, 1'b0);
            check("rst_idx", 32'(idx), 0);
            check("rst_enab", 32'(enab), 0);
            check("rst_busy", 32'(busy), 0);
        end

        // done while idle is ignored
        cycle(1'b0, 8'h00, 1'b1);
        check("idle_done_enab", 32'(enab), 0);

        cycle(1'b0, 8'h20, 1'b0);
        check("single_idx", 32'(idx), 5);
        check("single_enab", 32'(enab), 1);
        cycle(1'b0, 8'h00, 1'b1);
        check("release_enab", 32'(enab), 0);

        // full sweep with wrap, ptr restarted by reset
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b0, 8'hFF, 1'b0);
        check("sweep_first", 32'(idx), 0);
        for (int g = 0; g < 8; g++) begin
            cycle(1'b0, 8'hFF, 1'b0);
            check("sweep_hold", 32'(idx), 32'(g));
            check("sweep_hold_enab", 32'(enab), 1);
            cycle(1'b0, 8'hFF, 1'b1);
            check("sweep_next", 32'(idx), 32'((g + 1) % 8));
            check("sweep_enab", 32'(enab), 1);
`ifdef ARB_STATS_EN
            if (g == 6) check("sweep_cnt8", 32'(grant_cnt), 8);
`endif
        end

        // hold timeout alternation between requesters 0 and 3
        cycle(1'b1, 8'h00, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 8'h09, 1'b0);
            check("timeout_idx", 32'(idx), (((k - 1) / 4) % 2 == 1) ? 3 : 0);
            check("timeout_enab", 32'(enab), 1);
        end

        // owner drops its request
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b0, 8'h40, 1'b0);
        check("drop_own", 32'(idx), 6);
        cycle(1'b0, 8'h03, 1'b0);
        check("drop_idx", 32'(idx), 0);
        check("drop_enab", 32'(enab), 1);

        // reset during a grant
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b0, 8'h10, 1'b0);
        check("mid_own", 32'(idx), 4);
        cycle(1'b1, 8'h10, 1'b0);
        check("mid_rst_enab", 32'(enab), 0);
        check("mid_rst_idx", 32'(idx), 0);
        cycle(1'b0, 8'h11, 1'b0);
        check("post_rst_idx", 32'(idx), 0);
        check("post_rst_enab", 32'(enab), 1);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [7:0] rq;
            rq = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cycle(($urandom_range(0, 40) == 0), rq, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
